mcb_arb2: RTL and testbench
===========================

# mcb_arb2

Two-port arbiter that shares one sdrc_lite memory controller back-end (MCB) command/data interface between two MCB-side requesters, typically two Avalon wrappers. Each requester's command is held, and a winner is chosen by round-robin. One command at a time is issued to the back-end. Write-data requests and read-data returns are routed to the owning requester through per-direction in-order owner FIFOs.

## Interface
- MCB_B_W, 2, bank address width
- MCB_R_W, 13, row address width
- MCB_C_W, 9, column address width
- MCB_D_W, 16, data width
- MCB_BE_W, 2, byte-enable width
- ORD_DEPTH, 4, entries per owner FIFO (power of 2)

- csi_clockreset_clk  in  1  single clock
- csi_clockreset_reset_n  in  1  asynchronous, active-low reset
- mN_bb  in  1  command strobe from requester N (N=0,1), one-cycle pulse
- mN_wr_n  in  1  1=read, 0=write
- mN_bl  in  2  burst length code; beats = (bl+1)*4
- mN_ba / mN_ra / mN_ca  in  MCB_B_W / MCB_R_W / MCB_C_W  address
- mN_wdat  in  MCB_D_W  write data
- mN_wbe  in  MCB_BE_W  write byte enables
- mN_busy  out  1  requester must not pulse mN_bb
- mN_wdat_req  out  1  write beat request to requester N
- mN_rdat_vld  out  1  read beat valid for requester N
- mN_rdat  out  MCB_D_W  read data (mcb_rdat broadcast)
- mN_i_ready  out  1  mcb_i_ready passthrough
- mcb_bb, mcb_wr_n, mcb_bl, mcb_ba, mcb_ra, mcb_ca  out  to back-end (registered)
- mcb_wdat / mcb_wbe  out  MCB_D_W / MCB_BE_W  write-owner muxed
- mcb_busy, mcb_rdat_vld, mcb_wdat_req, mcb_i_ready  in  from back-end
- mcb_rdat  in  MCB_D_W  read data
- arb_err  out  1  sticky protocol error flag

## Operation
- **Hold registers.** One per requester. Capture {wr_n, bl, ba, ra, ca} when mN_bb=1 and hold_vld[N]=0, and set hold_vld[N]. If mN_bb arrives while hold_vld[N]=1, the command is dropped and arb_err is set.
- **Requester busy.** mN_busy = hold_vld[N] | mcb_busy | ~mcb_i_ready.
- **Issue FSM states.**
  - IDLE: go to ISSUE when all of these hold: any hold_vld, mcb_busy=0, mcb_i_ready=1, and the target owner FIFO is not full.
  - ISSUE: mcb_bb=1 for exactly one cycle. Clear the winner's hold_vld. Push {id, bl} into rd_ord (if wr_n=1) or wr_ord (if wr_n=0). Update last_gnt.
  - WAIT: unconditional single gap cycle for mcb_busy to rise, then return to IDLE.
- **Round-robin.** If both holds are valid, the requester not equal to last_gnt wins. If one is valid, it wins.
  - A candidate whose target FIFO is full is skipped.
  - If the other hold is valid and its target FIFO is not full, that one is granted instead.
- **Write routing.**
  - mcb_wdat_req is forwarded to the head owner of wr_ord.
  - mcb_wdat/mcb_wbe are muxed from that owner. They are 0 when wr_ord is empty.
  - Beat counter wcnt increments per mcb_wdat_req. When wcnt=={bl,2'b11}, wr_ord pops and wcnt resets to 0.
- **Read routing.** Same scheme using rd_ord, rcnt and mcb_rdat_vld.
- **Simultaneous push and pop.** A push and a pop on the same FIFO in the same cycle are both honoured; the count is unchanged.
- **Orphan beats.** mcb_rdat_vld or mcb_wdat_req with the corresponding FIFO empty is dropped. No requester sees it, and arb_err is set.
- **Outputs not listed elsewhere are registered.** Exceptions: mN_wdat_req, mN_rdat_vld, mcb_wdat and mcb_wbe are combinational from FIFO head state.

## Timing
- **Reset values.**
  - All mcb_* command outputs: 0.
  - mN_wdat_req, mN_rdat_vld, arb_err: 0.
  - FSM: IDLE.
  - last_gnt: 1, so m0 wins the first tie.
  - FIFOs empty, counters 0.
- **Command latency.** mN_bb in cycle t → hold_vld[N] in t+1 → mcb_bb high in t+2 if eligible.
- **Issue rate.** At most one mcb_bb every 3 cycles.
- **Beat routing.** Same cycle, zero latency.
- **Reset mid-burst.** Asserting reset during a burst clears everything immediately. Remaining beats after reset release count as orphans.

## Configuration
- `MCB_ARB2_FIXED_PRI_EN` defined: fixed priority, with m0 always winning over m1. last_gnt is not used.
- Not defined: round-robin as described in Operation.

## Structure
- Shared package mcb_arb_pkg holds:
  - FSM state enum {IDLE, ISSUE, WAIT};
  - owner-entry typedef {id, bl};
  - beat-last compare function ({bl,2'b11}).
- Sub-module mcb_arb_ord_fifo: synchronous FIFO, ORD_DEPTH x 3 bits, with push/pop/full/empty. Instantiated twice (rd_ord, wr_ord).

## Test plan
- **Single read.** m0 read with bl=0 (4 beats) → mcb_bb at t+2. Then 4 mcb_rdat_vld → m0_rdat_vld pulses 4 times, m1_rdat_vld stays 0.
- **Tie.** m0 and m1 pulse in the same cycle → m0 issued first, m1 issued 3 cycles later, and the next tie goes to m0 again (round-robin). With `MCB_ARB2_FIXED_PRI_EN`, m0 always wins the tie.
- **Interleaved writes.** m1 write bl=1 (8 beats) followed by m0 write bl=0 → 8 wdat_req routed to m1 with mcb_wdat=m1_wdat, then 4 routed to m0.
- **FIFO full.** Issue 4 reads with no return → the 5th read is held while a pending write still issues. One read return then frees a slot.
- **Errors.** mcb_rdat_vld with rd_ord empty → arb_err=1, both mN_rdat_vld=0. A double mN_bb pulse while the hold is full also sets arb_err.
- **Reset mid-burst.** Reset after beat 2 of an 8-beat read → FIFO empty, FSM IDLE, all outputs at reset values.

Source files
------------

// File: rtl/mcb_arb_pkg.sv
// mcb_arb_pkg: shared types and helpers for the two-port MCB arbiter
package mcb_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef struct packed {
    logic       id;
    logic [1:0] bl;
  } ord_t;
  function automatic logic beat_last(input logic [1:0] bl, input logic [3:0] cnt);
    return cnt == {bl, 2'b11};
  endfunction
endpackage

// File: rtl/mcb_arb2_if.sv
// mcb_arb2_if: sdrc_lite MCB command/data port; master issues commands, slave serves them
interface mcb_arb2_if #(
  parameter int MCB_B_W  = 2,
  parameter int MCB_R_W  = 13,
  parameter int MCB_C_W  = 9,
  parameter int MCB_D_W  = 16,
  parameter int MCB_BE_W = 2
);
  logic                bb;
  logic                wr_n;
  logic [1:0]          bl;
  logic [MCB_B_W-1:0]  ba;
  logic [MCB_R_W-1:0]  ra;
  logic [MCB_C_W-1:0]  ca;
  logic [MCB_D_W-1:0]  wdat;
  logic [MCB_BE_W-1:0] wbe;
  logic                busy;
  logic                wdat_req;
  logic                rdat_vld;
  logic [MCB_D_W-1:0]  rdat;
  logic                i_ready;
  modport master (output bb, wr_n, bl, ba, ra, ca, wdat, wbe,
                  input  busy, wdat_req, rdat_vld, rdat, i_ready);
  modport slave  (input  bb, wr_n, bl, ba, ra, ca, wdat, wbe,
                  output busy, wdat_req, rdat_vld, rdat, i_ready);
endinterface

// File: rtl/mcb_arb_ord_fifo.sv
// mcb_arb_ord_fifo: in-order owner FIFO of {id, bl} entries
module mcb_arb_ord_fifo
  import mcb_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  ord_t din,
  input  logic pop,
  output ord_t dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  ord_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign dout = mem[rp];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      mem <= '{default: '0};
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp <= wp + AW'(1);
      end
      if (do_pop) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/mcb_arb2.sv
// mcb_arb2: two-port round-robin arbiter onto one MCB back-end with in-order beat routing.
// Define MCB_ARB2_FIXED_PRI_EN for fixed priority (m0 always beats m1).
module mcb_arb2
  import mcb_arb_pkg::*;
#(
  parameter int MCB_B_W   = 2,
  parameter int MCB_R_W   = 13,
  parameter int MCB_C_W   = 9,
  parameter int MCB_D_W   = 16,
  parameter int MCB_BE_W  = 2,
  parameter int ORD_DEPTH = 4
) (
  input  logic       csi_clockreset_clk,
  input  logic       csi_clockreset_reset_n,
  mcb_arb2_if.slave  m0,
  mcb_arb2_if.slave  m1,
  mcb_arb2_if.master mcb,
  output logic       arb_err
);
  typedef struct packed {
    logic               wr_n;
    logic [1:0]         bl;
    logic [MCB_B_W-1:0] ba;
    logic [MCB_R_W-1:0] ra;
    logic [MCB_C_W-1:0] ca;
  } cmd_t;
  cmd_t cmd_in [2];
  cmd_t hold [2];
  logic [1:0] bb, hold_vld, elig;
  logic gnt, gnt_q, go, drop, orphan;
  logic rd_push, wr_push, rd_pop, wr_pop, rd_hit, wr_hit;
  logic rd_full, rd_empty, wr_full, wr_empty;
  logic [3:0] rcnt, wcnt;
  ord_t ent, rd_head, wr_head;
  state_t state;
  assign bb = {m1.bb, m0.bb};
  assign cmd_in[0] = {m0.wr_n, m0.bl, m0.ba, m0.ra, m0.ca};
  assign cmd_in[1] = {m1.wr_n, m1.bl, m1.ba, m1.ra, m1.ca};
  // a hold is only a candidate if its direction's owner FIFO has room
  for (genvar g = 0; g < 2; g++) begin : g_elig
    assign elig[g] = hold_vld[g] & ~(hold[g].wr_n ? rd_full : wr_full);
  end
`ifdef MCB_ARB2_FIXED_PRI_EN
  assign gnt = ~elig[0];
`else
  logic last_gnt;
  assign gnt = &elig ? ~last_gnt : elig[1];
  always_ff @(posedge csi_clockreset_clk or negedge csi_clockreset_reset_n)
    if (!csi_clockreset_reset_n) last_gnt <= 1'b1;
    else if (state == ISSUE) last_gnt <= gnt_q;
`endif
  assign go = |elig & ~mcb.busy & mcb.i_ready;
  assign drop = |(bb & hold_vld);
  always_ff @(posedge csi_clockreset_clk or negedge csi_clockreset_reset_n)
    if (!csi_clockreset_reset_n) begin
      hold_vld <= '0;
      hold <= '{default: '0};
    end else begin
      for (int n = 0; n < 2; n++)
        if (bb[n] && !hold_vld[n]) begin
          hold_vld[n] <= 1'b1;
          hold[n] <= cmd_in[n];
        end else if (state == ISSUE && gnt_q == 1'(n)) hold_vld[n] <= 1'b0;
    end
  always_ff @(posedge csi_clockreset_clk or negedge csi_clockreset_reset_n)
    if (!csi_clockreset_reset_n) begin
      state <= IDLE;
      gnt_q <= 1'b0;
      mcb.bb <= 1'b0;
      {mcb.wr_n, mcb.bl, mcb.ba, mcb.ra, mcb.ca} <= '0;
    end else begin
      case (state)
        IDLE: if (go) begin
          state <= ISSUE;
          gnt_q <= gnt;
          mcb.bb <= 1'b1;
          {mcb.wr_n, mcb.bl, mcb.ba, mcb.ra, mcb.ca} <= hold[gnt];
        end
        ISSUE: begin
          state <= WAIT;
          mcb.bb <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  assign ent = '{id: gnt_q, bl: mcb.bl};
  assign rd_push = state == ISSUE && mcb.wr_n;
  assign wr_push = state == ISSUE && !mcb.wr_n;
  mcb_arb_ord_fifo #(.DEPTH(ORD_DEPTH)) u_rd_ord (
    .clk(csi_clockreset_clk), .rst_n(csi_clockreset_reset_n),
    .push(rd_push), .din(ent), .pop(rd_pop), .dout(rd_head), .full(rd_full), .empty(rd_empty)
  );
  mcb_arb_ord_fifo #(.DEPTH(ORD_DEPTH)) u_wr_ord (
    .clk(csi_clockreset_clk), .rst_n(csi_clockreset_reset_n),
    .push(wr_push), .din(ent), .pop(wr_pop), .dout(wr_head), .full(wr_full), .empty(wr_empty)
  );
  assign wr_hit = mcb.wdat_req & ~wr_empty;
  assign rd_hit = mcb.rdat_vld & ~rd_empty;
  assign wr_pop = wr_hit & beat_last(wr_head.bl, wcnt);
  assign rd_pop = rd_hit & beat_last(rd_head.bl, rcnt);
  assign orphan = (mcb.wdat_req & wr_empty) | (mcb.rdat_vld & rd_empty);
  assign m0.wdat_req = wr_hit & ~wr_head.id;
  assign m1.wdat_req = wr_hit & wr_head.id;
  assign m0.rdat_vld = rd_hit & ~rd_head.id;
  assign m1.rdat_vld = rd_hit & rd_head.id;
  assign mcb.wdat = wr_empty ? '0 : wr_head.id ? m1.wdat : m0.wdat;
  assign mcb.wbe = wr_empty ? '0 : wr_head.id ? m1.wbe : m0.wbe;
  assign m0.rdat = mcb.rdat;
  assign m1.rdat = mcb.rdat;
  assign m0.i_ready = mcb.i_ready;
  assign m1.i_ready = mcb.i_ready;
  assign m0.busy = hold_vld[0] | mcb.busy | ~mcb.i_ready;
  assign m1.busy = hold_vld[1] | mcb.busy | ~mcb.i_ready;
  always_ff @(posedge csi_clockreset_clk or negedge csi_clockreset_reset_n)
    if (!csi_clockreset_reset_n) begin
      wcnt <= '0;
      rcnt <= '0;
      arb_err <= 1'b0;
    end else begin
      if (wr_hit) wcnt <= wr_pop ? '0 : wcnt + 4'd1;
      if (rd_hit) rcnt <= rd_pop ? '0 : rcnt + 4'd1;
      if (drop | orphan) arb_err <= 1'b1;
    end
endmodule

// File: tb/tb_mcb_arb2.sv
// tb_mcb_arb2: directed self-checking bench for mcb_arb2
module tb_mcb_arb2;
  logic clk = 1'b0, rst_n = 1'b0, arb_err;
  int tests = 0, fails = 0, n;
  mcb_arb2_if m0(), m1(), mcb();
  mcb_arb2 dut (
    .csi_clockreset_clk(clk), .csi_clockreset_reset_n(rst_n),
    .m0(m0), .m1(m1), .mcb(mcb), .arb_err(arb_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int k = 1);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step();
  endtask
  task automatic set(input int p, input logic wr_n, input logic [1:0] bl, input logic [12:0] ra);
    if (p == 0) begin
      m0.bb = 1'b1; m0.wr_n = wr_n; m0.bl = bl; m0.ra = ra;
    end else begin
      m1.bb = 1'b1; m1.wr_n = wr_n; m1.bl = bl; m1.ra = ra;
    end
  endtask
  task automatic pulse;
    step();
    m0.bb = 1'b0;
    m1.bb = 1'b0;
  endtask
  task automatic wait_bb(input int lim, output int cnt);
    cnt = -1;
    for (int i = 0; i < lim; i++) begin
      if (mcb.bb) begin
        cnt = i;
        return;
      end
      step();
    end
  endtask
  initial begin
    {m0.bb, m0.wr_n, m0.bl, m0.ba, m0.ra, m0.ca, m0.wdat, m0.wbe} = '0;
    {m1.bb, m1.wr_n, m1.bl, m1.ba, m1.ra, m1.ca, m1.wdat, m1.wbe} = '0;
    {mcb.busy, mcb.wdat_req, mcb.rdat_vld, mcb.rdat} = '0;
    mcb.i_ready = 1'b1;
    step(2);
    chk("rst_bb", mcb.bb, 0);
    chk("rst_wr_n", mcb.wr_n, 0);
    chk("rst_bl", mcb.bl, 0);
    chk("rst_err", arb_err, 0);
    chk("rst_busy", m0.busy, 0);
    rst_n = 1'b1;
    step();
    // single read, bl=0
    set(0, 1'b1, 2'd0, 13'h10);
    pulse();
    chk("rd_busy", m0.busy, 1);
    chk("rd_bb_t1", mcb.bb, 0);
    step();
    chk("rd_bb_t2", mcb.bb, 1);
    chk("rd_wr_n", mcb.wr_n, 1);
    chk("rd_ra", mcb.ra, 13'h10);
    step();
    chk("rd_bb_pulse", mcb.bb, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      mcb.rdat_vld = 1'b1;
      mcb.rdat = 16'(100 + i);
      #1;
      chk("rd_m0_vld", m0.rdat_vld, 1);
      chk("rd_m1_vld", m1.rdat_vld, 0);
      chk("rd_m0_dat", m0.rdat, 100 + i);
      step();
    end
    mcb.rdat_vld = 1'b0;
    #1;
    chk("rd_m0_done", m0.rdat_vld, 0);
    chk("rd_err", arb_err, 0);
    // tie right after an m0 grant
    set(0, 1'b1, 2'd0, 13'h10);
    set(1, 1'b1, 2'd0, 13'h20);
    pulse();
    wait_bb(10, n);
    chk("rr_first_lat", n, 1);
`ifdef MCB_ARB2_FIXED_PRI_EN
    chk("rr_first_ra", mcb.ra, 13'h10);
`else
    chk("rr_first_ra", mcb.ra, 13'h20);
`endif
    step();
    wait_bb(10, n);
    chk("rr_second_gap", n, 2);
    step(3);
    for (int i = 0; i < 8; i++) begin
      mcb.rdat_vld = 1'b1;
      #1;
`ifdef MCB_ARB2_FIXED_PRI_EN
      chk("rr_route_m0", m0.rdat_vld, i < 4);
`else
      chk("rr_route_m0", m0.rdat_vld, i >= 4);
`endif
      step();
    end
    mcb.rdat_vld = 1'b0;
    // tie from reset: m0, m1, then m0 again
    do_reset();
    set(0, 1'b1, 2'd0, 13'h10);
    set(1, 1'b1, 2'd0, 13'h20);
    pulse();
    wait_bb(10, n);
    chk("tie1_lat", n, 1);
    chk("tie1_ra", mcb.ra, 13'h10);
    step();
    wait_bb(10, n);
    chk("tie2_gap", n, 2);
    chk("tie2_ra", mcb.ra, 13'h20);
    step();
    set(0, 1'b1, 2'd0, 13'h10);
    set(1, 1'b1, 2'd0, 13'h20);
    pulse();
    wait_bb(10, n);
    chk("tie3_ra", mcb.ra, 13'h10);
    // interleaved writes
    do_reset();
    m0.wdat = 16'hA0A0; m0.wbe = 2'd1;
    m1.wdat = 16'hB1B1; m1.wbe = 2'd2;
    set(1, 1'b0, 2'd1, 13'h20);
    pulse();
    set(0, 1'b0, 2'd0, 13'h10);
    pulse();
    wait_bb(10, n);
    chk("wr1_lat", n, 0);
    chk("wr1_ra", mcb.ra, 13'h20);
    chk("wr1_wr_n", mcb.wr_n, 0);
    step();
    wait_bb(10, n);
    chk("wr2_gap", n, 2);
    chk("wr2_ra", mcb.ra, 13'h10);
    step(3);
    for (int i = 0; i < 12; i++) begin
      mcb.wdat_req = 1'b1;
      #1;
      chk("wr_m1_req", m1.wdat_req, i < 8);
      chk("wr_m0_req", m0.wdat_req, i >= 8);
      chk("wr_wdat", mcb.wdat, i < 8 ? 16'hB1B1 : 16'hA0A0);
      chk("wr_wbe", mcb.wbe, i < 8 ? 2'd2 : 2'd1);
      step();
    end
    mcb.wdat_req = 1'b0;
    #1;
    chk("wr_wdat_empty", mcb.wdat, 0);
    chk("wr_err", arb_err, 0);
    // read FIFO full: fifth read waits, write still goes
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set(0, 1'b1, 2'd0, 13'h10);
      pulse();
      wait_bb(10, n);
      chk("full_fill_lat", n, 1);
      step();
    end
    set(0, 1'b1, 2'd0, 13'h11);
    set(1, 1'b0, 2'd0, 13'h20);
    pulse();
    wait_bb(10, n);
    chk("full_wr_lat", n, 1);
    chk("full_wr_ra", mcb.ra, 13'h20);
    step();
    wait_bb(8, n);
    chk("full_rd_held", n, -1);
    chk("full_m0_busy", m0.busy, 1);
    for (int i = 0; i < 4; i++) begin
      mcb.rdat_vld = 1'b1;
      step();
    end
    mcb.rdat_vld = 1'b0;
    wait_bb(10, n);
    chk("full_rd_lat", n, 1);
    chk("full_rd_ra", mcb.ra, 13'h11);
    chk("full_rd_wr_n", mcb.wr_n, 1);
    // orphan read beat
    do_reset();
    mcb.rdat_vld = 1'b1;
    #1;
    chk("orph_rd_m0", m0.rdat_vld, 0);
    chk("orph_rd_m1", m1.rdat_vld, 0);
    step();
    mcb.rdat_vld = 1'b0;
    chk("orph_rd_err", arb_err, 1);
    // orphan write request
    do_reset();
    mcb.wdat_req = 1'b1;
    #1;
    chk("orph_wr_m0", m0.wdat_req, 0);
    chk("orph_wr_wdat", mcb.wdat, 0);
    step();
    mcb.wdat_req = 1'b0;
    chk("orph_wr_err", arb_err, 1);
    // double strobe while hold is full
    do_reset();
    chk("dbl_err0", arb_err, 0);
    mcb.busy = 1'b1;
    set(0, 1'b1, 2'd0, 13'h10);
    pulse();
    chk("dbl_busy", m0.busy, 1);
    chk("dbl_no_err", arb_err, 0);
    set(0, 1'b1, 2'd0, 13'h10);
    pulse();
    chk("dbl_err", arb_err, 1);
    mcb.busy = 1'b0;
    mcb.i_ready = 1'b0;
    #1;
    chk("nrdy_busy", m1.busy, 1);
    chk("nrdy_pass", m1.i_ready, 0);
    mcb.i_ready = 1'b1;
    // reset in the middle of an 8-beat read
    do_reset();
    set(0, 1'b1, 2'd1, 13'h10);
    pulse();
    wait_bb(10, n);
    step(3);
    for (int i = 0; i < 2; i++) begin
      mcb.rdat_vld = 1'b1;
      step();
    end
    mcb.rdat_vld = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_ra", mcb.ra, 0);
    chk("mid_wr_n", mcb.wr_n, 0);
    chk("mid_err", arb_err, 0);
    step(2);
    rst_n = 1'b1;
    step();
    mcb.rdat_vld = 1'b1;
    #1;
    chk("mid_orph_m0", m0.rdat_vld, 0);
    step();
    mcb.rdat_vld = 1'b0;
    chk("mid_orph_err", arb_err, 1);
    set(0, 1'b1, 2'd0, 13'h12);
    pulse();
    wait_bb(10, n);
    chk("mid_idle_lat", n, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
